// File: rtl/mem_responder_multi_pkg.sv
// rtl/mem_responder_multi_pkg.sv - shared access-size codes and responder state encodings
package mem_responder_multi_pkg;

  // Access size codes carried on iFunct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_M_IDLE   = 2'd0,
    ST_M_WAIT   = 2'd1,
    ST_M_ACCESS = 2'd2,
    ST_M_HOLD   = 2'd3
  } state_t;

  // True for the five size codes the responder understands
  function automatic logic f3_known(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load lane select/extend and store byte-enable/lane replication
module mem_lane_align
  import mem_responder_multi_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_wlanes,
  output logic [3:0]  o_be
);

  logic [31:0] w_shift;

  // Addressed byte moved down to lane 0; word accesses are aligned so the shift is zero
  assign w_shift = i_word >> {i_addr_lo, 3'b000};

  // Load extension by access size
  always_comb begin
    o_load = 32'h0;
    case (i_funct3)
      F3_LB:   o_load = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LBU:  o_load = {24'h0, w_shift[7:0]};
      F3_LH:   o_load = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LHU:  o_load = {16'h0, w_shift[15:0]};
      F3_LW:   o_load = w_shift;
      default: o_load = 32'h0;
    endcase
  end

  // Store data replicated across lanes; byte enables pick which lanes actually land
  always_comb begin
    o_be     = 4'b0000;
    o_wlanes = i_wdata;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        o_be     = 4'b0001 << i_addr_lo;
        o_wlanes = {4{i_wdata[7:0]}};
      end
      F3_LH, F3_LHU: begin
        o_be     = 4'b0011 << i_addr_lo;
        o_wlanes = {2{i_wdata[15:0]}};
      end
      F3_LW: begin
        o_be     = 4'b1111;
        o_wlanes = i_wdata;
      end
      default: begin
        o_be     = 4'b0000;
        o_wlanes = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder_multi.sv
// rtl/mem_responder_multi.sv - multicycle memory responder with wait states and sized access
module mem_responder_multi
  import mem_responder_multi_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oReadData,
  output logic        oMemReady,
  output logic        oBusy,
  output logic        oErr
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state, w_next;
  logic        r_rd, r_wr;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_f3;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_ram [DEPTH];

  logic             w_strobe, w_differs, w_accept, w_do_access;
  logic             w_rd, w_wr;
  logic [31:0]      w_addr, w_wdata;
  logic [2:0]       w_f3;
  logic [31:0]      w_off;
  logic             w_range_err, w_align_err, w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word, w_load, w_wlanes;
  logic [3:0]       w_be;

  assign w_strobe  = iMemRead | iMemWrite;
  assign w_differs = {iMemRead, iMemWrite, iAddress, iWriteData, iFunct3} !=
                     {r_rd, r_wr, r_addr, r_wdata, r_f3};

  // Next state: HOLD swallows a held request but takes a changed one with no bubble
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      ST_M_IDLE: begin
        if (w_strobe) w_accept = 1'b1;
      end
      ST_M_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next      = ST_M_ACCESS;
          w_do_access = 1'b1;
        end
      end
      ST_M_ACCESS: w_next = ST_M_HOLD;
      ST_M_HOLD: begin
        if (!w_strobe)      w_next   = ST_M_IDLE;
        else if (w_differs) w_accept = 1'b1;
      end
      default: w_next = ST_M_IDLE;
    endcase
    if (w_accept) begin
      if (WAIT_CYCLES == 0) begin
        w_next      = ST_M_ACCESS;
        w_do_access = 1'b1;
      end else begin
        w_next = ST_M_WAIT;
      end
    end
  end

  // The access edge uses live inputs when accepting and executing together, else the captured copy
  assign w_rd    = w_accept ? iMemRead   : r_rd;
  assign w_wr    = w_accept ? iMemWrite  : r_wr;
  assign w_addr  = w_accept ? iAddress   : r_addr;
  assign w_wdata = w_accept ? iWriteData : r_wdata;
  assign w_f3    = w_accept ? iFunct3    : r_f3;

  assign w_off       = w_addr - BASE_ADDR;
  assign w_range_err = (w_addr < BASE_ADDR) || (w_off >= SPAN);
  assign w_align_err = (((w_f3 == F3_LH) || (w_f3 == F3_LHU)) && w_addr[0]) ||
                       ((w_f3 == F3_LW) && (w_addr[1:0] != 2'b00));
  assign w_err       = (w_rd & w_wr) | w_range_err | w_align_err | ~f3_known(w_f3);
  assign w_idx       = w_off[IDX_W+1:2];
  assign w_word      = r_ram[w_idx];

  mem_lane_align u_align (
    .i_addr_lo (w_addr[1:0]),
    .i_funct3  (w_f3),
    .i_word    (w_word),
    .i_wdata   (w_wdata),
    .o_load    (w_load),
    .o_wlanes  (w_wlanes),
    .o_be      (w_be)
  );

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= ST_M_IDLE;
    else       r_state <= w_next;
  end

  // Captured request, wait counter and registered response
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_f3    <= 3'b000;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd    <= iMemRead;
        r_wr    <= iMemWrite;
        r_addr  <= iAddress;
        r_wdata <= iWriteData;
        r_f3    <= iFunct3;
        r_cnt   <= CNT_INIT;
        r_err   <= 1'b0;
      end else if ((r_state == ST_M_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_access) begin
        r_err <= w_err;
        if (w_err)     r_rdata <= 32'h0;
        else if (w_rd) r_rdata <= w_load;
      end
    end
  end

  // Byte-enabled RAM write; held off while reset is asserted so an abandoned store never lands
  always_ff @(posedge iCLK) begin
    if (w_do_access && w_wr && !w_err && iRST) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  assign oReadData = r_rdata;
  assign oErr      = r_err;
  assign oMemReady = (r_state == ST_M_ACCESS);
  assign oBusy     = (r_state == ST_M_WAIT) || (r_state == ST_M_ACCESS);

endmodule

// File: tb/tb_mem_responder_multi.sv
// tb/tb_mem_responder_multi.sv - scoreboard bench for mem_responder_multi at zero and three wait states
module tb_mem_responder_multi;
  import mem_responder_multi_pkg::*;

  logic        clk = 1'b0;
  logic        rst0, rst3, rd0, wr0, rd3, wr3;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, busy0, busy3, err0, err3;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy3_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_multi #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .iCLK(clk), .iRST(rst0), .iMemRead(rd0), .iMemWrite(wr0), .iAddress(addr),
    .iWriteData(wdata), .iFunct3(f3), .oReadData(rdata0), .oMemReady(rdy0),
    .oBusy(busy0), .oErr(err0)
  );

  mem_responder_multi #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
    .iCLK(clk), .iRST(rst3), .iMemRead(rd3), .iMemWrite(wr3), .iAddress(addr),
    .iWriteData(wdata), .iFunct3(f3), .oReadData(rdata3), .oMemReady(rdy3),
    .oBusy(busy3), .oErr(err3)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rdy0) begin
      if (q0.size() == 0) chk_eq("spurious_rdy0", 32'(rdy0), 32'd0);
      else begin
        e = q0.pop_front();
        chk_eq("rdy0_cycle", 32'(cyc), 32'(e.cyc));
        chk_eq("err0", 32'(err0), 32'(e.err));
        if (e.chk) chk_eq("rdata0", rdata0, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy3) busy3_cnt++;
    if (rdy3) begin
      if (q3.size() == 0) chk_eq("spurious_rdy3", 32'(rdy3), 32'd0);
      else begin
        e = q3.pop_front();
        chk_eq("rdy3_cycle", 32'(cyc), 32'(e.cyc));
        chk_eq("err3", 32'(err3), 32'(e.err));
        if (e.chk) chk_eq("rdata3", rdata3, e.data);
      end
    end
  end

  task automatic req(input bit sel, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f, input int hold,
                     input logic [31:0] ed, input logic ee, input bit ck);
    exp_t e;
    addr  = a;
    wdata = d;
    f3    = f;
    if (sel) begin rd3 = r; wr3 = w; rd0 = 1'b0; wr0 = 1'b0; end
    else     begin rd0 = r; wr0 = w; rd3 = 1'b0; wr3 = 1'b0; end
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc + 1 + (sel ? 3 : 0);
    e.chk  = ck;
    if (sel) q3.push_back(e);
    else     q0.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q3.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk_eq("drain", 32'(q0.size() + q3.size()), 32'd0);
  endtask

  initial begin
    rst0 = 1'b0; rst3 = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    addr = 32'h0; wdata = 32'h0; f3 = F3_LW;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_rdata0", rdata0, 32'h0);
    chk_eq("rst_rdy0", 32'(rdy0), 32'd0);
    chk_eq("rst_busy0", 32'(busy0), 32'd0);
    chk_eq("rst_err0", 32'(err0), 32'd0);
    chk_eq("rst_rdata3", rdata3, 32'h0);
    chk_eq("rst_rdy3", 32'(rdy3), 32'd0);
    chk_eq("rst_busy3", 32'(busy3), 32'd0);
    chk_eq("rst_err3", 32'(err3), 32'd0);
    rst0 = 1'b1; rst3 = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states, back-to-back requests accepted from HOLD
    req(0, 0, 1, 32'h10, 32'hDEADBEEF, F3_LW,  2, 32'h0,        0, 0);
    req(0, 1, 0, 32'h10, 32'h0,        F3_LW,  2, 32'hDEADBEEF, 0, 1);
    req(0, 0, 1, 32'h13, 32'h12345680, F3_LB,  2, 32'h0,        0, 0);
    req(0, 1, 0, 32'h13, 32'h0,        F3_LB,  2, 32'hFFFFFF80, 0, 1);
    req(0, 1, 0, 32'h13, 32'h0,        F3_LBU, 2, 32'h00000080, 0, 1);
    req(0, 1, 0, 32'h10, 32'h0,        F3_LW,  2, 32'h80ADBEEF, 0, 1);
    req(0, 1, 0, 32'h12, 32'h0,        F3_LH,  2, 32'hFFFF80AD, 0, 1);
    req(0, 1, 0, 32'h10, 32'h0,        F3_LHU, 2, 32'h0000BEEF, 0, 1);
    req(0, 1, 0, 32'h11, 32'h0,        F3_LB,  2, 32'hFFFFFFBE, 0, 1);
    req(0, 0, 1, 32'h12, 32'hAAAA1234, F3_LH,  2, 32'h0,        0, 0);
    req(0, 1, 0, 32'h10, 32'h0,        F3_LW,  2, 32'h1234BEEF, 0, 1);
    // Error cases: data forced to zero, RAM untouched
    req(0, 1, 0, 32'h11,   32'h0,        F3_LH,  2, 32'h0, 1, 1);
    req(0, 1, 0, 32'h12,   32'h0,        F3_LW,  2, 32'h0, 1, 1);
    req(0, 1, 1, 32'h10,   32'h0,        F3_LW,  2, 32'h0, 1, 1);
    req(0, 1, 0, 32'h1000, 32'h0,        F3_LW,  2, 32'h0, 1, 1);
    req(0, 1, 0, 32'h10,   32'h0,        3'b011, 2, 32'h0, 1, 1);
    req(0, 0, 1, 32'h12,   32'hFFFFFFFF, F3_LW,  2, 32'h0, 1, 1);
    req(0, 0, 1, 32'h1000, 32'hFFFFFFFF, F3_LB,  2, 32'h0, 1, 1);
    req(0, 1, 0, 32'h10,   32'h0,        F3_LW,  2, 32'h1234BEEF, 0, 1);
    // Last word in range
    req(0, 0, 1, 32'hFFC, 32'hA5A5A5A5, F3_LW, 2, 32'h0,        0, 0);
    req(0, 1, 0, 32'hFFC, 32'h0,        F3_LW, 2, 32'hA5A5A5A5, 0, 1);
    idle(2);
    drain();

    // Three wait states: store held until ready, then load with no IDLE gap
    req(1, 0, 1, 32'h20, 32'hCAFEF00D, F3_LW, 5, 32'h0,        0, 0);
    req(1, 1, 0, 32'h20, 32'h0,        F3_LW, 5, 32'hCAFEF00D, 0, 1);
    idle(2);
    drain();
    busy3_cnt = 0;
    req(1, 1, 0, 32'h20, 32'h0, F3_LW, 6, 32'hCAFEF00D, 0, 1);
    idle(3);
    chk_eq("busy3_cycles", 32'(busy3_cnt), 32'd4);
    drain();

    // Reset dropped during WAIT of a store abandons it
    req(1, 0, 1, 32'h30, 32'h11111111, F3_LW, 5, 32'h0,        0, 0);
    req(1, 1, 0, 32'h30, 32'h0,        F3_LW, 5, 32'h11111111, 0, 1);
    idle(2);
    drain();
    addr = 32'h30; wdata = 32'h22222222; f3 = F3_LW; wr3 = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("wait_busy3", 32'(busy3), 32'd1);
    rst3 = 1'b0;
    #1;
    chk_eq("arst_rdata3", rdata3, 32'h0);
    chk_eq("arst_rdy3", 32'(rdy3), 32'd0);
    chk_eq("arst_busy3", 32'(busy3), 32'd0);
    chk_eq("arst_err3", 32'(err3), 32'd0);
    wr3 = 1'b0;
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    req(1, 1, 0, 32'h30, 32'h0, F3_LW, 5, 32'h11111111, 0, 1);
    idle(5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
